pixel_line_feeder: RTL and testbench

- Streams one 16x16 block of 32-bit pixels from a word-addressed pixel memory into the interpolator's `data_in` port.
- The block walks the pixels one line at a time, rows or columns. Each line is framed with edge-replicated padding so the interpolator's 8-deep tap buffer sees a full 6-tap window.
- Alongside the data beats, it marks the beats on which the interpolator's a/b/c results are valid and gives the destination subpixel index for each.
- It is the producer that sits upstream of the interpolator and drives its `data_in` and `ready` inputs.

---
 rtl/pixel_line_feeder.sv | 160 ++++++++++++++++
 tb/tb_pixel_line_feeder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_line_feeder.sv
// pixel_line_feeder: walks a 16x16 block of pixels line by line (rows or
// columns), pads each line by edge replication to 29 beats and feeds the
// interpolator, flagging the 16 beats per line whose result is captured.
module pixel_line_feeder #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              col_mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              ready,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              cap_valid,
   output logic [7:0]        cap_idx,
   output logic              busy,
   output logic              done
);

   localparam int unsigned LINE_W = 4;
   localparam int unsigned BEAT_W = 5;

   localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(28);
   localparam logic [BEAT_W-1:0] FIRST_CAP   = BEAT_W'(13);
   localparam logic [BEAT_W-1:0] FIRST_RD_B  = BEAT_W'(8);   // beat 8 fetches pos 1
   localparam logic [BEAT_W-1:0] LAST_RD_B   = BEAT_W'(22);  // beat 22 fetches pos 15
   localparam logic [BEAT_W-1:0] RD_POS_OFS  = BEAT_W'(7);   // pos(b+1) = b - 7
   localparam logic [LINE_W-1:0] LAST_LINE   = LINE_W'(15);
   localparam logic [LINE_W-1:0] POS_FIRST   = LINE_W'(0);
   localparam logic [LINE_W-1:0] LINE_STEP   = LINE_W'(1);
   localparam logic [BEAT_W-1:0] BEAT_STEP   = BEAT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PRIME  = 2'd1,
      S_STREAM = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   state_e              state_q;
   logic [LINE_W-1:0]   line_q;
   logic [BEAT_W-1:0]   beat_q;
   logic                col_q;
   logic [ADDR_W-1:0]   base_q;
   logic                rdv_q;      // mem_rdata carries a requested pixel this cycle
   logic [DATA_W-1:0]   hold_q;     // most recently returned pixel
   logic [DATA_W-1:0]   last_q;     // last presented beat, shown while stalled
   logic [ADDR_W-1:0]   addr_q;     // last issued read address
   logic [7:0]          idx_q;      // last issued capture index

   logic                present;
   logic                rd_now;
   logic [ADDR_W-1:0]   rd_addr;
   logic [DATA_W-1:0]   pix;
   logic [LINE_W-1:0]   cap_j;
   logic [7:0]          cur_idx;

   // Block pixel (line, pos) to memory address, row or column walk.
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] base,
                                                  input logic              col,
                                                  input logic [LINE_W-1:0] line,
                                                  input logic [LINE_W-1:0] pos);
      if (col) pix_addr = base + ADDR_W'({pos, line});
      else     pix_addr = base + ADDR_W'({line, pos});
   endfunction

   // Beat presentation, read issue and capture tagging for the current cycle.
   always_comb begin
      present = 1'b0;
      rd_now  = 1'b0;
      rd_addr = addr_q;
      pix     = rdv_q ? mem_rdata : hold_q;
      cap_j   = LINE_W'(beat_q - FIRST_CAP);
      cur_idx = col_q ? {cap_j, line_q} : {line_q, cap_j};

      if (state_q == S_STREAM) present = ready;

      if (state_q == S_PRIME) begin
         rd_now  = 1'b1;
         rd_addr = pix_addr(base_q, col_q, POS_FIRST, POS_FIRST);
      end else if (present) begin
         if (beat_q == LAST_BEAT) begin
            if (line_q != LAST_LINE) begin
               rd_now  = 1'b1;
               rd_addr = pix_addr(base_q, col_q, line_q + LINE_STEP, POS_FIRST);
            end
         end else if (beat_q >= FIRST_RD_B && beat_q <= LAST_RD_B) begin
            rd_now  = 1'b1;
            rd_addr = pix_addr(base_q, col_q, line_q, LINE_W'(beat_q - RD_POS_OFS));
         end
      end

      mem_rd     = rd_now;
      mem_addr   = rd_now ? rd_addr : addr_q;
      data_valid = present;
      data_out   = present ? pix : last_q;
      cap_valid  = present && (beat_q >= FIRST_CAP);
      cap_idx    = cap_valid ? cur_idx : idx_q;
      busy       = (state_q == S_PRIME) || (state_q == S_STREAM);
      done       = (state_q == S_DONE);
   end

   // Pass sequencing, line/beat counters and the data/address hold registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         line_q  <= '0;
         beat_q  <= '0;
         col_q   <= 1'b0;
         base_q  <= '0;
         rdv_q   <= 1'b0;
         hold_q  <= '0;
         last_q  <= '0;
         addr_q  <= '0;
         idx_q   <= '0;
      end else begin
         rdv_q <= rd_now;
         if (rdv_q)     hold_q <= mem_rdata;
         if (rd_now)    addr_q <= rd_addr;
         if (present)   last_q <= pix;
         if (cap_valid) idx_q  <= cur_idx;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  col_q   <= col_mode;
                  base_q  <= base_addr;
                  line_q  <= '0;
                  beat_q  <= '0;
                  state_q <= S_PRIME;
               end
            end
            S_PRIME: begin
               state_q <= S_STREAM;
            end
            S_STREAM: begin
               if (present) begin
                  if (beat_q == LAST_BEAT) begin
                     beat_q <= '0;
                     if (line_q == LAST_LINE) state_q <= S_DONE;
                     else                     line_q  <= line_q + LINE_STEP;
                  end else begin
                     beat_q <= beat_q + BEAT_STEP;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_line_feeder.sv
// tb_pixel_line_feeder: scoreboard bench; a per-pass reference list of beats
// and reads is built from the line/padding/address rules and a negedge
// monitor compares every DUT beat, read and status flag against it.
module tb_pixel_line_feeder;

   localparam int unsigned PASS_BEATS = 464;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        col_mode = 1'b0;
   logic [31:0] base_addr = '0;
   logic        ready = 1'b0;
   logic        mem_rd;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic [31:0] data_out;
   logic        data_valid;
   logic        cap_valid;
   logic [7:0]  cap_idx;
   logic        busy;
   logic        done;

   int unsigned tests = 0;
   int unsigned fails = 0;

   typedef struct packed {
      logic [31:0] data;
      logic        cap;
      logic [7:0]  idx;
   } beat_t;

   beat_t       beat_q[$];
   logic [31:0] rd_q[$];
   logic [31:0] mem_key = '0;

   logic        chk_en = 1'b0;
   logic        exp_valid = 1'b0;
   logic        exp_busy = 1'b0;
   logic        exp_done = 1'b0;
   logic        exp_stall = 1'b0;
   logic [31:0] exp_last_data = '0;
   logic [7:0]  exp_last_idx = '0;

   pixel_line_feeder #(.DATA_W(32), .ADDR_W(32)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .col_mode  (col_mode),
      .base_addr (base_addr),
      .ready     (ready),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .data_out  (data_out),
      .data_valid(data_valid),
      .cap_valid (cap_valid),
      .cap_idx   (cap_idx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clock = ~clock;

   // Synchronous memory: keyed pixel one cycle after a read, garbage otherwise.
   always @(posedge clock) mem_rdata <= mem_rd ? (mem_addr ^ mem_key) : $urandom;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_addr(input logic col, input logic [31:0] base,
                                            input int l, input int p);
      return col ? base + 32'(16 * p + l) : base + 32'(16 * l + p);
   endfunction

   // Reference pass: 16 lines x 29 padded beats, 16 reads per line.
   task automatic load_model(input logic col, input logic [31:0] base);
      beat_q.delete();
      rd_q.delete();
      for (int l = 0; l < 16; l++) begin
         for (int p = 0; p < 16; p++) rd_q.push_back(ref_addr(col, base, l, p));
         for (int b = 0; b < 29; b++) begin
            int    p;
            beat_t e;
            p = (b < 9) ? 0 : (b < 24) ? b - 8 : 15;
            e.data = ref_addr(col, base, l, p) ^ mem_key;
            e.cap  = (b >= 13);
            e.idx  = (b >= 13) ? (col ? 8'(l + 16 * (b - 13)) : 8'(16 * l + (b - 13))) : 8'd0;
            beat_q.push_back(e);
         end
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_mem_rd"},     32'(mem_rd), 32'd0);
      check({tag, "_mem_addr"},   mem_addr, 32'd0);
      check({tag, "_data_out"},   data_out, 32'd0);
      check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
      check({tag, "_cap_valid"},  32'(cap_valid), 32'd0);
      check({tag, "_cap_idx"},    32'(cap_idx), 32'd0);
      check({tag, "_busy"},       32'(busy), 32'd0);
      check({tag, "_done"},       32'(done), 32'd0);
   endtask

   // Monitor: compares each cycle's outputs against the scoreboard.
   always @(negedge clock) begin
      beat_t e;
      if (!reset_n) begin
         exp_last_data = '0;
         exp_last_idx  = '0;
      end else if (chk_en) begin
         check("data_valid", 32'(data_valid), 32'(exp_valid));
         check("busy", 32'(busy), 32'(exp_busy));
         check("done", 32'(done), 32'(exp_done));
         if (mem_rd) begin
            if (rd_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_read: got addr %h expected no read", mem_addr);
            end else begin
               check("rd_addr", mem_addr, rd_q.pop_front());
            end
         end
         if (data_valid) begin
            if (beat_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: got %h expected no beat", data_out);
            end else begin
               e = beat_q.pop_front();
               check("data_out", data_out, e.data);
               check("cap_valid", 32'(cap_valid), 32'(e.cap));
               if (e.cap) begin
                  check("cap_idx", 32'(cap_idx), 32'(e.idx));
                  exp_last_idx = e.idx;
               end
               exp_last_data = e.data;
            end
         end else begin
            check("cap_valid_idle", 32'(cap_valid), 32'd0);
         end
         if (exp_stall) begin
            check("stall_mem_rd", 32'(mem_rd), 32'd0);
            check("stall_data_hold", data_out, exp_last_data);
            check("stall_idx_hold", 32'(cap_idx), 32'(exp_last_idx));
         end
      end
   end

   // One pass: mode 0 = no stalls, 1 = directed stalls, 2 = random stalls.
   // abort_beat >= 0 drops reset asynchronously once that many beats went out.
   task automatic run_pass(input logic col, input logic [31:0] base, input int mode,
                           input int abort_beat);
      int presented;
      int n;
      bit rdy;
      presented = 0;
      load_model(col, base);
      @(posedge clock); #1;                       // cycle 0: start sampled
      start = 1'b1; col_mode = col; base_addr = base; ready = 1'($urandom);
      exp_valid = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_stall = 1'b0;
      chk_en = 1'b1;
      @(posedge clock); #1;                       // cycle 1: PRIME, ready ignored
      start = 1'b0; col_mode = 1'($urandom); base_addr = $urandom; ready = 1'($urandom);
      exp_busy = 1'b1;
      n = 1;
      while (presented < PASS_BEATS) begin
         @(posedge clock); #1;
         n++;
         if (abort_beat >= 0 && presented == abort_beat) begin
            chk_en = 1'b0;
            ready = 1'b1;
            #2;
            reset_n = 1'b0;
            #1;
            check_zero("abort");
            return;
         end
         case (mode)
            1:       rdy = !(n == 12 || n == 13 || n == 14 || n == 33);
            2:       rdy = ($urandom_range(0, 3) != 0);
            default: rdy = 1'b1;
         endcase
         ready     = rdy;
         exp_valid = rdy;
         exp_stall = !rdy;
         start     = (n == 50);                   // ignored mid-pass
         col_mode  = 1'($urandom);
         base_addr = $urandom;
         if (rdy) presented++;
      end
      @(posedge clock); #1;                       // DONE
      start = 1'b1; ready = 1'($urandom);
      exp_valid = 1'b0; exp_stall = 1'b0; exp_busy = 1'b0; exp_done = 1'b1;
      @(posedge clock); #1;                       // back in IDLE
      start = 1'b0; ready = 1'($urandom);
      exp_done = 1'b0;
      @(posedge clock); #1;
      ready = 1'b0;
      check("beats_left", 32'(beat_q.size()), 32'd0);
      check("reads_left", 32'(rd_q.size()), 32'd0);
   endtask

   initial begin
      #12;
      check_zero("reset");
      @(posedge clock); #1;
      reset_n = 1'b1;
      chk_en  = 1'b1;
      @(negedge clock); #1;
      check_zero("idle");

      mem_key = '0;
      run_pass(1'b0, 32'h0000_0100, 0, -1);       // row pass, identity memory
      run_pass(1'b1, 32'h0000_0000, 0, -1);       // column pass, identity memory
      run_pass(1'b0, 32'h0000_0100, 1, -1);       // directed stalls

      mem_key = $urandom;
      run_pass(1'b0, $urandom, 2, 100);           // aborted by reset at beat 100
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      run_pass(1'b0, 32'h0000_0100, 2, -1);       // restart after abort

      run_pass(1'b1, 32'hFFFF_FF80, 2, -1);       // address wrap
      for (int k = 0; k < 3; k++) begin
         mem_key = $urandom;
         run_pass(1'($urandom), $urandom, 2, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
